// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one external barrel shifter between two
// requesters. S1 registers the selected request and drives the shifter; S2
// captures the shifter result and presents it with valid/ready backpressure.
module shift_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [4:0]       req0_shamt,
   input  logic [31:0]      req0_data,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [4:0]       req1_shamt,
   input  logic [31:0]      req1_data,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [1:0]       sh_c,
   output logic [4:0]       sh_shamt,
   output logic [31:0]      sh_in,
   input  logic [31:0]      sh_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_src,
   output logic [TAG_W-1:0] res_tag
);

   logic             op_valid;
   logic [1:0]       op_q;
   logic [4:0]       shamt_q;
   logic [31:0]      data_q;
   logic             src_q;
   logic [TAG_W-1:0] tag_q;
   logic             prio;

   logic s2_load, s1_free, sel0, sel1, grant0, grant1;

   // Pipeline advance and round-robin grant; readies held low during reset.
   always_comb begin
      s2_load = op_valid && (!res_valid || res_ready);
      s1_free = !op_valid || s2_load;
      sel0    = req0_valid && (!req1_valid || !prio);
      sel1    = req1_valid && (!req0_valid || prio);
      grant0  = sel0 && s1_free && rst_n;
      grant1  = sel1 && s1_free && rst_n;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign sh_c     = op_q;
   assign sh_shamt = shamt_q;
   assign sh_in    = data_q;

   // S1 operand register and priority pointer; prio moves only on an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid <= 1'b0;
         op_q     <= '0;
         shamt_q  <= '0;
         data_q   <= '0;
         src_q    <= 1'b0;
         tag_q    <= '0;
         prio     <= 1'b0;
      end else if (grant0) begin
         op_valid <= 1'b1;
         op_q     <= req0_op;
         shamt_q  <= req0_shamt;
         data_q   <= req0_data;
         src_q    <= 1'b0;
         tag_q    <= req0_tag;
         prio     <= 1'b1;
      end else if (grant1) begin
         op_valid <= 1'b1;
         op_q     <= req1_op;
         shamt_q  <= req1_shamt;
         data_q   <= req1_data;
         src_q    <= 1'b1;
         tag_q    <= req1_tag;
         prio     <= 1'b0;
      end else if (s2_load) begin
         op_valid <= 1'b0;
      end
   end

   // S2 result register: reload from the shifter or retire on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_src   <= 1'b0;
         res_tag   <= '0;
      end else if (s2_load) begin
         res_valid <= 1'b1;
         res_data  <= sh_out;
         res_src   <= src_q;
         res_tag   <= tag_q;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one barrel shifter instance between two requesters: the integer-pipeline ALU path on port 0 and the multi-cycle unit on port 1. Each requester presents operation, shift amount, operand and tag on a valid/ready handshake. The block arbitrates round-robin and drives the external shifter from a registered operand stage. It returns the result through a registered output stage with valid/ready backpressure, so the shifter never sits on a combinational path between requester and consumer.

## Interface
- TAG_W, 4, width of the requester-supplied tag echoed with each result.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_op / req1_op  in  2  shift code: 00 logical right, 01 logical left, 10 rotate right, 11 rotate left.
- req0_shamt / req1_shamt  in  5  shift amount 0..31.
- req0_data / req1_data  in  32  operand.
- req0_tag / req1_tag  in  TAG_W  opaque tag.
- sh_c  out  2  to shifter op select.
- sh_shamt  out  5  to shifter amount.
- sh_in  out  32  to shifter operand.
- sh_out  in  32  shifter result, combinational from sh_c/sh_shamt/sh_in.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  shifted value.
- res_src  out  1  requester index that issued the result.
- res_tag  out  TAG_W  tag of that request.

## Operation
- The pipeline has two stages.
  - S1 (operand register): op_valid, op, shamt, data, src, tag. sh_c/sh_shamt/sh_in are driven directly from the S1 registers.
  - S2 (result register): res_valid, res_data ← sh_out, res_src, res_tag.
- Advance conditions:
  - s2_load = op_valid && (!res_valid || res_ready).
  - s1_free = !op_valid || s2_load.
- Arbitration: pointer prio (0 or 1) marks the preferred requester.
  - Only one requester valid: that requester is granted.
  - Both valid: requester prio is granted.
  - grant_k = selected && s1_free; reqk_ready = grant_k. Ready may depend on same-cycle valid of both requesters. At most one ready is high per cycle.
- On an accept from requester k: S1 loads k's fields, src←k, prio←!k. prio changes only on an accept.
- S2 state:
  - On s2_load: res_valid←1 and S2 fields load.
  - Else on res_valid&&res_ready: res_valid←0.
- Results return strictly in acceptance order; no reordering, duplication or drop.
- Requester fields need not be held stable while ready is low. The fields are sampled only on the accepting edge.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - op_valid=0, res_valid=0, prio=0.
  - All S1 and S2 data fields 0, so sh_c=0, sh_shamt=0, sh_in=0, res_data=0, res_src=0, res_tag=0.
  - req*_ready=0 while in reset.
- Latency: request accepted at edge N → res_valid high after edge N+1 (visible cycle N+1) if S2 is free.
- Throughput: one result per cycle with res_ready held high; both requesters streaming alternate 0,1,0,1.
- Backpressure: with res_ready low, a third request is blocked (ready low) once S1 and S2 are both occupied. Same-cycle res_ready high with S2 and S1 full: S2 reloads from S1 and S1 accepts a new request in the same edge.
- Boundaries:
  - shamt=0 returns the operand unchanged for all four ops.
  - shamt=31 rotate left equals rotate right by 1.
  - Idle cycles (no valid) leave prio unchanged.
- Reset mid-operation: in-flight S1/S2 contents are discarded. No result is produced after rst_n rises until a new accept.

## Test plan
- Req0 op=01, shamt=4, data=0x0000000F, tag=3, res_ready=1 → res_valid the cycle after accept with res_data=0x000000F0, res_src=0, res_tag=3.
- Both valid from reset, each with 3 requests (req1 op=10, shamt=8, data=0x12345678) → grant order 0,1,0,1,0,1; each req1 result is 0x78123456 with res_src=1.
- Issue 3 back-to-back requests with res_ready=0 for 5 cycles → exactly 2 accepted, ready low thereafter. After res_ready=1, results drain in order with no gaps or loss.
- Boundaries with data=0x80000001:
  - op=11, shamt=31 → 0xC0000000.
  - op=00, shamt=31 → 0x00000001.
  - op=01, shamt=0 → 0x80000001.
- Assert rst_n low for 1 cycle while S1 and S2 are full → res_valid=0 and sh_in=0 immediately; no stale result appears afterwards; prio restarts at 0.
- Randomized valid/ready on both ports for 10k cycles versus a reference model → results match in order, every accepted tag is returned once, and no requester waits more than 1 grant while the other is valid.
